// File: rtl/dac_pkg.sv
// Shared types for the stereo serial DAC front end.
// Build option: DAC_OFFSET_BINARY_EN converts captured two's complement
// words to offset binary by inverting the MSB at load time.
package dac_pkg;
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } dac_state_t;

  // Word actually shifted out for a captured sample.
  function automatic logic [DATA_W-1:0] to_dac_word(input sample_t s);
`ifdef DAC_OFFSET_BINARY_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction
endpackage

// File: rtl/dac_chan_shifter.sv
// One channel of the DAC serializer: parallel load, MSB-first left shift.
// Ports:
//   clk    clock (clk_12 domain)
//   reset  synchronous active-high reset
//   load   capture din into the shift register
//   shift  shift left one bit (MSB leaves first)
//   clr    clear the register so the serial line idles low
//   din    parallel word to send
//   sout   serial output, the register MSB (registered)
module dac_chan_shifter
  import dac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              sout
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[DATA_W-2:0], 1'b0};
    end
  end

  assign sout = shreg[DATA_W-1];

endmodule

// File: rtl/dac_serializer.sv
// Stereo serial DAC front end. On each rising edge of the clk_48 sample
// strobe it captures leftIn/rightIn, shifts both words MSB-first on DL/DR,
// then pulses LL/LR for LATCH_W cycles so the DAC latches on the fall.
// Build option: DAC_OFFSET_BINARY_EN (see dac_pkg::to_dac_word).
// Ports:
//   clk_12   sole clock
//   reset    synchronous active-high reset
//   clk_48   sample-rate strobe (data input, sampled on clk_12)
//   leftIn   signed left sample
//   rightIn  signed right sample
//   DL, DR   serial data, MSB first
//   LL, LR   latch strobes, active-high, identical timing
//
// state | meaning
// IDLE  | waiting for a strobe rising edge; DL/DR/LL/LR low
// SHIFT | DATA_W cycles, one bit per cycle, MSB first
// LATCH | LATCH_W cycles, LL/LR high, DL/DR hold bit 0
module dac_serializer
  import dac_pkg::*;
#(
  parameter int LATCH_W = 1
) (
  input  logic    clk_12,
  input  logic    reset,
  input  logic    clk_48,
  input  sample_t leftIn,
  input  sample_t rightIn,
  output logic    DL,
  output logic    DR,
  output logic    LL,
  output logic    LR
);

  localparam int CNT_MAX = (DATA_W > LATCH_W) ? DATA_W : LATCH_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  dac_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             clk_48_q;
  logic             tick;
  logic             load, shift, clr;
  logic             latch_q;

  assign tick = clk_48 & ~clk_48_q;

  // Down-counter holds the cycles remaining in the current phase; the
  // phase ends when it reaches zero. On the last SHIFT cycle no shift is
  // issued so bit 0 stays on the line through LATCH.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    shift      = 1'b0;
    clr        = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          load       = 1'b1;
          state_next = SHIFT;
          cnt_next   = CNT_W'(DATA_W - 1);
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          state_next = LATCH;
          cnt_next   = CNT_W'(LATCH_W - 1);
        end else begin
          shift    = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_next = IDLE;
          clr        = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clk_48_q <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      clk_48_q <= clk_48;
      latch_q  <= (state_next == LATCH);
    end
  end

  assign LL = latch_q;
  assign LR = latch_q;

  dac_chan_shifter u_left (
    .clk   (clk_12),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .clr   (clr),
    .din   (to_dac_word(leftIn)),
    .sout  (DL)
  );

  dac_chan_shifter u_right (
    .clk   (clk_12),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .clr   (clr),
    .din   (to_dac_word(rightIn)),
    .sout  (DR)
  );

endmodule

// File: tb/tb_dac_serializer.sv
// Directed self-checking bench for dac_serializer.
module tb_dac_serializer;

  logic        clk_12;
  logic        reset;
  logic        clk_48;
  logic [15:0] leftIn;
  logic [15:0] rightIn;
  logic        DL, DR, LL, LR;

  int errors = 0;
  int checks = 0;

  logic [15:0] sr_l, sr_r;
  logic [15:0] cap_l, cap_r;
  int          pulses = 0;
  int          p0;

  dac_serializer #(.LATCH_W(1)) dut (
    .clk_12  (clk_12),
    .reset   (reset),
    .clk_48  (clk_48),
    .leftIn  (leftIn),
    .rightIn (rightIn),
    .DL      (DL),
    .DR      (DR),
    .LL      (LL),
    .LR      (LR)
  );

  initial begin
    clk_12 = 1'b0;
    forever #5 clk_12 = ~clk_12;
  end

  // Receiver model: shift serial data while the latch is low, take the
  // word when the latch falls.
  always @(posedge clk_12) begin
    if (LL !== 1'b1) begin
      sr_l <= {sr_l[14:0], DL};
      sr_r <= {sr_r[14:0], DR};
    end
  end

  always @(negedge LL) begin
    cap_l = sr_l;
    cap_r = sr_r;
    pulses++;
  end

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef DAC_OFFSET_BINARY_EN
    return {~w[15], w[14:0]};
`else
    return w;
`endif
  endfunction

  // Expected {DL,DR,LL,LR} on cycle k after the tick cycle.
  function automatic logic [3:0] exp_out(input int k, input logic [15:0] el,
                                         input logic [15:0] er);
    if (k >= 1 && k <= 16) return {el[16-k], er[16-k], 2'b00};
    else if (k == 17)      return {el[0], er[0], 2'b11};
    else                   return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle strobe pulse; returns at the negedge of cycle T+1.
  task automatic start_tick(input logic [15:0] l, input logic [15:0] r);
    leftIn  = l;
    rightIn = r;
    clk_48  = 1'b1;
    @(negedge clk_12);
    clk_48  = 1'b0;
  endtask

  // Check cycles lo..hi; returns at the negedge of cycle hi+1.
  task automatic frame_cycles(input string tag, input int lo, input int hi,
                              input logic [15:0] l, input logic [15:0] r);
    for (int k = lo; k <= hi; k++) begin
      chk($sformatf("%s_cyc%0d", tag, k), {28'd0, DL, DR, LL, LR},
          {28'd0, exp_out(k, exp_word(l), exp_word(r))});
      @(negedge clk_12);
    end
  endtask

  initial begin
    reset   = 1'b1;
    clk_48  = 1'b0;
    leftIn  = 16'h0000;
    rightIn = 16'h0000;

    // Reset with the strobe toggling.
    @(negedge clk_12);
    chk("reset_c1", {28'd0, DL, DR, LL, LR}, 32'd0);
    clk_48 = 1'b1;
    @(negedge clk_12);
    chk("reset_c2", {28'd0, DL, DR, LL, LR}, 32'd0);
    clk_48 = 1'b0;
    reset  = 1'b0;
    @(negedge clk_12);
    chk("idle_after_reset", {28'd0, DL, DR, LL, LR}, 32'd0);

    // Frame A, inputs change mid-frame.
    p0 = pulses;
    start_tick(16'h0009, 16'h0006);
    frame_cycles("A", 1, 7, 16'h0009, 16'h0006);
    leftIn  = 16'h0004;
    rightIn = 16'h0008;
    frame_cycles("A", 8, 18, 16'h0009, 16'h0006);
    chk("A_cap_l", {16'd0, cap_l}, {16'd0, exp_word(16'h0009)});
    chk("A_cap_r", {16'd0, cap_r}, {16'd0, exp_word(16'h0006)});
    chk("A_pulses", pulses - p0, 32'd1);

    // Frame B picks up the new inputs.
    repeat (3) @(negedge clk_12);
    p0 = pulses;
    start_tick(16'h0004, 16'h0008);
    frame_cycles("B", 1, 18, 16'h0004, 16'h0008);
    chk("B_cap_l", {16'd0, cap_l}, {16'd0, exp_word(16'h0004)});
    chk("B_cap_r", {16'd0, cap_r}, {16'd0, exp_word(16'h0008)});
    chk("B_pulses", pulses - p0, 32'd1);

    // Frame C: extreme values.
    repeat (3) @(negedge clk_12);
    p0 = pulses;
    start_tick(16'h8000, 16'h7FFF);
    frame_cycles("C", 1, 18, 16'h8000, 16'h7FFF);
    chk("C_cap_l", {16'd0, cap_l}, {16'd0, exp_word(16'h8000)});
    chk("C_cap_r", {16'd0, cap_r}, {16'd0, exp_word(16'h7FFF)});

    // Reset pulse at bit 8 aborts the frame.
    repeat (3) @(negedge clk_12);
    p0 = pulses;
    start_tick(16'hA5C3, 16'h3C5A);
    frame_cycles("D", 1, 8, 16'hA5C3, 16'h3C5A);
    reset = 1'b1;
    @(negedge clk_12);
    chk("D_abort_outputs", {28'd0, DL, DR, LL, LR}, 32'd0);
    reset = 1'b0;
    repeat (24) @(negedge clk_12);
    chk("D_abort_outputs_late", {28'd0, DL, DR, LL, LR}, 32'd0);
    chk("D_no_pulse", pulses - p0, 32'd0);

    // Full frame after the abort.
    p0 = pulses;
    start_tick(16'h1234, 16'hFEDC);
    frame_cycles("E", 1, 18, 16'h1234, 16'hFEDC);
    chk("E_cap_l", {16'd0, cap_l}, {16'd0, exp_word(16'h1234)});
    chk("E_cap_r", {16'd0, cap_r}, {16'd0, exp_word(16'hFEDC)});
    chk("E_pulses", pulses - p0, 32'd1);

    // Extra strobe edge during SHIFT is ignored.
    repeat (3) @(negedge clk_12);
    p0 = pulses;
    start_tick(16'h0F0F, 16'hC3C3);
    frame_cycles("F", 1, 4, 16'h0F0F, 16'hC3C3);
    clk_48 = 1'b1;
    frame_cycles("F", 5, 5, 16'h0F0F, 16'hC3C3);
    clk_48 = 1'b0;
    frame_cycles("F", 6, 18, 16'h0F0F, 16'hC3C3);
    repeat (24) @(negedge clk_12);
    chk("F_idle_after", {28'd0, DL, DR, LL, LR}, 32'd0);
    chk("F_pulses", pulses - p0, 32'd1);
    chk("F_cap_l", {16'd0, cap_l}, {16'd0, exp_word(16'h0F0F)});
    chk("F_cap_r", {16'd0, cap_r}, {16'd0, exp_word(16'hC3C3)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
